// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner: time-multiplexed driver for an N-digit common-anode
// seven-segment display. It advances one digit per scan_en pulse and adds
// hex/decimal encoding, decimal points, per-digit enables, leading-zero
// blanking, masked blinking and anti-ghosting dead time.
module sevenseg_scanner #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned BLINK_DIV    = 2048
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scan_en,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      hex_mode,
    input  logic                      lz_blank,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp
);

    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_TOP = BLINK_W'(BLINK_DIV - 1);
    localparam logic [6:0]         SEG_OFF   = 7'h7F;

    logic [IDX_W-1:0]      idx_q,         idx_d;
    logic [BLANK_W-1:0]    blank_cnt_q,   blank_cnt_d;
    logic [BLINK_W-1:0]    blink_cnt_q,   blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] an_q,          an_d;
    logic [6:0]            seg_q,         seg_d;
    logic                  dp_q,          dp_d;

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  zero_acc;
    logic [3:0]            cur_nib;
    logic                  lz_hit;
    logic                  dark;

    // Active-low a..g pattern for one nibble; 10..15 blank unless hex_mode.
    function automatic logic [6:0] encode(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        s = SEG_OFF;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = hex ? 7'b0001000 : SEG_OFF;
            4'hB: s = hex ? 7'b1100000 : SEG_OFF;
            4'hC: s = hex ? 7'b0110001 : SEG_OFF;
            4'hD: s = hex ? 7'b1000010 : SEG_OFF;
            4'hE: s = hex ? 7'b0110000 : SEG_OFF;
            4'hF: s = hex ? 7'b0111000 : SEG_OFF;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Split the digit bus into nibbles and flag positions whose nibble and
    // every more-significant nibble are zero.
    always_comb begin
        zero_acc   = 1'b1;
        upper_zero = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            nib[i] = digits[4*i +: 4];
        end
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_acc      = zero_acc & (nib[i] == 4'h0);
            upper_zero[i] = zero_acc;
        end
    end

    // Scan index, dead-time and blink bookkeeping.
    always_comb begin
        idx_d         = idx_q;
        blank_cnt_d   = blank_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (scan_en) begin
            idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            blank_cnt_d = BLANK_MAX;
            if (blink_cnt_q == BLINK_TOP) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end else if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - BLANK_W'(1);
        end
    end

    // Next display drive for the digit at idx: dark or a single lit anode.
    always_comb begin
        cur_nib = nib[idx_q];
        lz_hit  = lz_blank && (idx_q != '0) && upper_zero[idx_q];
        dark    = (blank_cnt_q != '0) || !digit_en[idx_q] ||
                  (blink_phase_q && blink_mask[idx_q]) || lz_hit;
        an_d    = '1;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        if (!dark) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = encode(cur_nib, hex_mode);
            dp_d  = ~dp_in[idx_q];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            blank_cnt_q   <= BLANK_MAX;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
        end else begin
            idx_q         <= idx_d;
            blank_cnt_q   <= blank_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
